// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and access sequencer for a single-port,
// synchronous-read data memory. Each access takes three cycles:
// sample/issue, memory access (grant pulse), response (rvalid pulse).
module dmem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [31:0]       mem_a,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_owner;      // port that owns the access in flight
  logic                r_is_write;   // access in flight is a write
  logic                r_last_gnt;   // most recently granted port
  logic                w_any_req;
  logic                w_win;        // winning port index for this sample
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

  // Arbitration: pick the winning port and mux its request fields.
  always_comb begin
    w_any_req   = req0 | req1;
    w_win       = 1'b0;
    w_sel_we    = we0;
    w_sel_addr  = addr0;
    w_sel_wdata = wdata0;
    if (req0 && req1) begin
      if (FIXED_PRIO != 0) begin
        w_win = 1'b0;
      end else begin
        w_win = ~r_last_gnt;
      end
    end else if (req1) begin
      w_win = 1'b1;
    end else begin
      w_win = 1'b0;
    end
    if (w_win) begin
      w_sel_we    = we1;
      w_sel_addr  = addr1;
      w_sel_wdata = wdata1;
    end else begin
      w_sel_we    = we0;
      w_sel_addr  = addr0;
      w_sel_wdata = wdata0;
    end
  end

  // Next-state logic: IDLE waits for a request, then ISSUE and RESP follow unconditionally.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = ST_ISSUE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: w_state_nxt = ST_RESP;
      ST_RESP:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State register plus registered memory controls, grant and response strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_owner    <= 1'b0;
      r_is_write <= 1'b0;
      r_last_gnt <= 1'b1;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      mem_a      <= 32'h0000_0000;
      mem_wd     <= {DATA_W{1'b0}};
      mem_we     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          rvalid0 <= 1'b0;
          rvalid1 <= 1'b0;
          if (w_any_req) begin
            mem_a      <= 32'(w_sel_addr);
            mem_wd     <= w_sel_wdata;
            mem_we     <= w_sel_we;
            gnt0       <= ~w_win;
            gnt1       <= w_win;
            r_owner    <= w_win;
            r_is_write <= w_sel_we;
            r_last_gnt <= w_win;
          end else begin
            mem_we <= 1'b0;
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
          end
        end
        ST_ISSUE: begin
          // Memory samples the controls on this edge; response follows next cycle.
          mem_we  <= 1'b0;
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          rvalid0 <= ~r_owner;
          rvalid1 <= r_owner;
        end
        ST_RESP: begin
          mem_we  <= 1'b0;
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          rvalid0 <= 1'b0;
          rvalid1 <= 1'b0;
        end
        default: begin
          mem_we  <= 1'b0;
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          rvalid0 <= 1'b0;
          rvalid1 <= 1'b0;
        end
      endcase
    end
  end

  // Read data steering: memory data appears one cycle after ISSUE, so it is
  // passed through to the owner only during RESP of a read.
  always_comb begin
    rdata0 = {DATA_W{1'b0}};
    rdata1 = {DATA_W{1'b0}};
    if ((r_state == ST_RESP) && !r_is_write) begin
      if (r_owner) begin
        rdata1 = mem_rdata;
      end else begin
        rdata0 = mem_rdata;
      end
    end else begin
      rdata0 = {DATA_W{1'b0}};
      rdata1 = {DATA_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: one round-robin and one fixed-priority instance
// driven by the same requesters, each with its own memory and reference model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [7:0]  addr0 = 8'h00, addr1 = 8'h00;
  logic [31:0] wdata0 = 32'h0, wdata1 = 32'h0;

  logic [1:0]  gnt0_w, gnt1_w, rvalid0_w, rvalid1_w, mem_we_w;
  logic [31:0] rdata0_w [2];
  logic [31:0] rdata1_w [2];
  logic [31:0] mem_a_w [2];
  logic [31:0] mem_wd_w [2];
  logic [31:0] mem_rdata_w [2];

  logic [31:0] mem [2][256];
  bit          preloaded = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          glog0[$];
  int          glog1[$];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .FIXED_PRIO(0)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0_w[0]), .rvalid0(rvalid0_w[0]), .rdata0(rdata0_w[0]),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1_w[0]), .rvalid1(rvalid1_w[0]), .rdata1(rdata1_w[0]),
    .mem_a(mem_a_w[0]), .mem_wd(mem_wd_w[0]), .mem_we(mem_we_w[0]),
    .mem_rdata(mem_rdata_w[0])
  );

  dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0_w[1]), .rvalid0(rvalid0_w[1]), .rdata0(rdata0_w[1]),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1_w[1]), .rvalid1(rvalid1_w[1]), .rdata1(rdata1_w[1]),
    .mem_a(mem_a_w[1]), .mem_wd(mem_wd_w[1]), .mem_we(mem_we_w[1]),
    .mem_rdata(mem_rdata_w[1])
  );

  // Synchronous-read memories (256 x 32), preloaded with DEADBEEF at word 5.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!preloaded) begin
        for (int i = 0; i < 256; i++) mem[k][i] <= (i == 5) ? 32'hDEADBEEF : 32'h0;
        mem_rdata_w[k] <= 32'h0;
      end else begin
        if (mem_we_w[k]) mem[k][mem_a_w[k][7:0]] <= mem_wd_w[k];
        mem_rdata_w[k] <= mem[k][mem_a_w[k][7:0]];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // phase: 0 = free, 1 = grant cycle, 2 = response cycle
  int          phase [2];
  bit          own [2], wr [2], last [2];
  logic [31:0] exp_a [2], exp_wd [2], exp_rd [2];
  logic [31:0] ref_mem [2][256];

  initial begin
    bit win;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) ref_mem[k][i] = (i == 5) ? 32'hDEADBEEF : 32'h0;
      phase[k] = 0; own[k] = 1'b0; wr[k] = 1'b0; last[k] = 1'b1;
      exp_a[k] = 32'h0; exp_wd[k] = 32'h0; exp_rd[k] = 32'h0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          phase[k] = 0; own[k] = 1'b0; wr[k] = 1'b0; last[k] = 1'b1;
          exp_a[k] = 32'h0; exp_wd[k] = 32'h0; exp_rd[k] = 32'h0;
        end else if (phase[k] != 0) begin
          phase[k] = (phase[k] + 1) % 3;
        end else if (req0 || req1) begin
          if (req0 && req1) win = (k == 1) ? 1'b0 : !last[k];
          else win = req1;
          last[k] = win;
          own[k]  = win;
          wr[k]   = win ? we1 : we0;
          exp_a[k]  = {24'h0, (win ? addr1 : addr0)};
          exp_wd[k] = win ? wdata1 : wdata0;
          if (wr[k]) ref_mem[k][exp_a[k][7:0]] = exp_wd[k];
          else exp_rd[k] = ref_mem[k][exp_a[k][7:0]];
          phase[k] = 1;
        end
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (preloaded) begin
        for (int k = 0; k < 2; k++) begin
          check($sformatf("gnt0[%0d]", k), {31'h0, gnt0_w[k]}, {31'h0, (phase[k] == 1 && !own[k])});
          check($sformatf("gnt1[%0d]", k), {31'h0, gnt1_w[k]}, {31'h0, (phase[k] == 1 && own[k])});
          check($sformatf("rvalid0[%0d]", k), {31'h0, rvalid0_w[k]}, {31'h0, (phase[k] == 2 && !own[k])});
          check($sformatf("rvalid1[%0d]", k), {31'h0, rvalid1_w[k]}, {31'h0, (phase[k] == 2 && own[k])});
          check($sformatf("mem_we[%0d]", k), {31'h0, mem_we_w[k]}, {31'h0, (phase[k] == 1 && wr[k])});
          check($sformatf("mem_a[%0d]", k), mem_a_w[k], exp_a[k]);
          check($sformatf("mem_wd[%0d]", k), mem_wd_w[k], exp_wd[k]);
          check($sformatf("rdata0[%0d]", k), rdata0_w[k],
                (phase[k] == 2 && !own[k] && !wr[k]) ? exp_rd[k] : 32'h0);
          check($sformatf("rdata1[%0d]", k), rdata1_w[k],
                (phase[k] == 2 && own[k] && !wr[k]) ? exp_rd[k] : 32'h0);
        end
      end
    end
  end

  // Grant order log, as observed on the DUT pins.
  initial begin
    forever begin
      @(negedge clk);
      if (gnt0_w[0]) glog0.push_back(0);
      if (gnt1_w[0]) glog0.push_back(1);
      if (gnt0_w[1]) glog1.push_back(0);
      if (gnt1_w[1]) glog1.push_back(1);
    end
  end

  // One access on instance 0's view; returns grant status and observations.
  task automatic do_access(input bit p, input bit we, input logic [7:0] a, input logic [31:0] wd,
                           output bit ok, output logic [31:0] a_g, output logic [31:0] rd,
                           output bit rv, output int we_n, output int other_n);
    ok = 1'b0; a_g = 32'h0; rd = 32'h0; rv = 1'b0; we_n = 0; other_n = 0;
    if (p) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd; end
    else   begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      we_n += int'(mem_we_w[0]);
      if ((p ? gnt1_w[0] : gnt0_w[0]) == 1'b1) begin
        ok = 1'b1; a_g = mem_a_w[0];
        other_n += int'(p ? gnt0_w[0] : gnt1_w[0]);
        break;
      end
    end
    if (p) req1 = 1'b0; else req0 = 1'b0;
    @(negedge clk);
    we_n += int'(mem_we_w[0]);
    rv = p ? rvalid1_w[0] : rvalid0_w[0];
    rd = p ? rdata1_w[0] : rdata0_w[0];
    other_n += int'(p ? rvalid0_w[0] : rvalid1_w[0]);
    @(negedge clk);
    we_n += int'(mem_we_w[0]);
  endtask

  int rr_exp [6] = '{0, 1, 0, 1, 1, 1};
  int fp_exp [6] = '{0, 0, 0, 0, 1, 1};

  initial begin
    bit ok, rv;
    logic [31:0] a_g, rd;
    int we_n, other_n, cnt;

    repeat (2) @(negedge clk);
    preloaded = 1'b1;
    // Reset-state checks while rst_n is still low.
    check("reset_gnt0", {31'h0, gnt0_w[0]}, 32'h0);
    check("reset_mem_a", mem_a_w[0], 32'h0);
    check("reset_mem_we", {31'h0, mem_we_w[1]}, 32'h0);

    // Both ports request continuously from reset.
    req0 = 1'b1; addr0 = 8'h05; req1 = 1'b1; addr1 = 8'h20;
    glog0.delete(); glog1.delete();
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    req0 = 1'b0;
    repeat (6) @(negedge clk);
    req1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rr_log_len", glog0.size(), 32'd6);
    check("fp_log_len", glog1.size(), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < glog0.size()) check($sformatf("rr_order[%0d]", i), glog0[i], rr_exp[i]);
      if (i < glog1.size()) check($sformatf("fp_order[%0d]", i), glog1[i], fp_exp[i]);
    end

    // Port 0 read of preloaded word 5.
    do_access(1'b0, 1'b0, 8'h05, 32'h0, ok, a_g, rd, rv, we_n, other_n);
    check("t1_granted", {31'h0, ok}, 32'h1);
    check("t1_mem_a", a_g, 32'h0000_0005);
    check("t1_rvalid", {31'h0, rv}, 32'h1);
    check("t1_rdata", rd, 32'hDEADBEEF);
    check("t1_we_cnt", we_n, 32'd0);
    check("t1_other_port", other_n, 32'd0);

    // Port 1 write then read back.
    do_access(1'b1, 1'b1, 8'h10, 32'h12345678, ok, a_g, rd, rv, we_n, other_n);
    check("t2w_granted", {31'h0, ok}, 32'h1);
    check("t2w_we_cnt", we_n, 32'd1);
    check("t2w_rvalid", {31'h0, rv}, 32'h1);
    check("t2w_rdata", rd, 32'h0);
    do_access(1'b1, 1'b0, 8'h10, 32'h0, ok, a_g, rd, rv, we_n, other_n);
    check("t2r_granted", {31'h0, ok}, 32'h1);
    check("t2r_rdata", rd, 32'h12345678);
    check("t2r_we_cnt", we_n, 32'd0);

    // Request pulse that never reaches a sampling edge.
    #1 req0 = 1'b1; we0 = 1'b1;
    #2 req0 = 1'b0; we0 = 1'b0;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      cnt += int'(gnt0_w[0]) + int'(gnt0_w[1]) + int'(mem_we_w[0]) + int'(mem_we_w[1]);
    end
    check("t5_no_grant", cnt, 32'd0);

    // Reset during ISSUE of a port 0 read.
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h05;
    @(negedge clk);
    check("t6_gnt_before_rst", {31'h0, gnt0_w[0]}, 32'h1);
    req0 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("t6_rst_gnt0[%0d]", k), {31'h0, gnt0_w[k]}, 32'h0);
      check($sformatf("t6_rst_mem_a[%0d]", k), mem_a_w[k], 32'h0);
      check($sformatf("t6_rst_mem_we[%0d]", k), {31'h0, mem_we_w[k]}, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      cnt += int'(rvalid0_w[0]) + int'(rvalid0_w[1]);
    end
    check("t6_no_rvalid", cnt, 32'd0);
    req0 = 1'b1; req1 = 1'b1; addr1 = 8'h10;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("t6_tie_gnt0[%0d]", k), {31'h0, gnt0_w[k]}, 32'h1);
      check($sformatf("t6_tie_gnt1[%0d]", k), {31'h0, gnt1_w[k]}, 32'h0);
    end
    req0 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (gnt1_w[0] && gnt1_w[1]) begin ok = 1'b1; break; end
    end
    check("t6_port1_after", {31'h0, ok}, 32'h1);
    req1 = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and access sequencer for the single-port, synchronous-read data memory (256 x 32 words, write-enable, registered read data with one-cycle latency).
- Port 0 is the core load/store unit; port 1 is a secondary master such as a DMA or debug unit.
- Selects one requester per access and drives registered memory controls.
- Waits out the memory's one-cycle read latency, then returns a response strobe and read data to the winning port.

Parameters:
ADDR_W, 8, word-address width of each requester; zero-extended onto the 32-bit memory address.
DATA_W, 32, data width; must equal the memory word width.
FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins ties.

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
req0  in  1  port 0 access request
we0  in  1  port 0 write (1) / read (0)
addr0  in  ADDR_W  port 0 word address
wdata0  in  DATA_W  port 0 write data
gnt0  out  1  port 0 grant, 1-cycle pulse
rvalid0  out  1  port 0 response valid, 1-cycle pulse
rdata0  out  DATA_W  port 0 read data, valid while rvalid0=1
req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1
mem_a  out  32  memory address (A)
mem_wd  out  DATA_W  memory write data (WriteData)
mem_we  out  1  memory write enable (WE)
mem_rdata  in  DATA_W  memory read data (ReadData)

Behaviour:
- Reset value of every output is 0, applied immediately on rst_n low: gnt*, rvalid*, rdata*, mem_a, mem_wd, mem_we. State goes to IDLE.
- The round-robin pointer last_gnt resets to 1, so port 0 wins the first tie.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: at a clock edge where any req is high, select the winner, then:
    - register mem_a = zero-extended addr, mem_wd = wdata, mem_we = we of the winner;
    - pulse the winner's gnt for the following cycle;
    - latch owner and is_write;
    - go to ISSUE.
    If no req is high, stay in IDLE with mem_we=0.
  - ISSUE: memory samples mem_a/mem_we/mem_wd on this edge. Arbiter clears mem_we, asserts the owner's rvalid for the following cycle, and goes to RESP.
  - RESP: the owner's rvalid=1 for exactly this cycle. The owner's rdata = mem_rdata for a read and 0 for a write. Next edge returns to IDLE. No arbitration happens in RESP.
- Latency from the req-sampling edge: gnt high in cycle +1, rvalid high in cycle +2. Throughput is one access per 3 cycles.
- Arbitration:
  - If only one req is high, that port wins.
  - If both are high and FIXED_PRIO=1, port 0 wins.
  - If both are high and FIXED_PRIO=0, the port not equal to last_gnt wins.
  - last_gnt updates on every grant.
- Requester rules:
  - Hold req/we/addr/wdata stable until gnt is seen.
  - May drop req in the gnt cycle or later.
  - Dropping req before gnt withdraws the request; no grant is issued for it.
  - A req held high past gnt is treated as a new request at the next IDLE sample.
- The non-owner port never sees gnt or rvalid and its rdata stays 0. The owner's rdata is 0 outside its rvalid cycle.
- mem_a and mem_wd hold their last values outside ISSUE. mem_we is high only during the ISSUE cycle.
- Reset mid-operation (ISSUE or RESP): the access is abandoned and no rvalid is produced. A write already sampled by memory may have completed.

Test Plan:
1. Port 0 read, addr0=8'h05, memory preloaded 32'hDEADBEEF at 5, req1=0 -> gnt0 in cycle +1 with mem_a=32'h5 and mem_we=0; rvalid0 with rdata0=32'hDEADBEEF in cycle +2; gnt1 and rvalid1 never asserted.
2. Port 1 write addr1=8'h10, wdata1=32'h12345678, then port 1 read addr1=8'h10 -> mem_we=1 for exactly one cycle on the write, with rdata1=0 on the write's rvalid1; the read returns rdata1=32'h12345678.
3. FIXED_PRIO=0, both ports request continuously from reset -> grant order 0,1,0,1; every 3-cycle slot delivers exactly one rvalid to the matching port.
4. FIXED_PRIO=1, both ports request continuously -> port 0 granted every slot; port 1 is granted only after req0 drops.
5. req0 raised and dropped before an IDLE sample edge -> no gnt0, FSM stays IDLE, mem_we stays 0.
6. rst_n pulsed low during ISSUE of a port 0 read -> all outputs 0 immediately; no rvalid0 afterwards; the next request after reset is granted normally, with port 0 winning a tie.
